// File: rtl/decode_pkg.sv
// decode_pkg: types and default widths shared by the decode stage 2
// micro-op sequencer and the EIP incrementer.
//   useq_state_t : sequencer state (IDLE = entry micro-op, SEQ = continuation)
//   DEF_*        : default parameter values for the decode_useq slice
package decode_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } useq_state_t;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_NEXT_W   = 7;
  localparam int DEF_EIP_W    = 32;
  localparam int DEF_LEN_W    = 4;
  localparam int DEF_MAX_UOPS = 8;

endpackage

// File: rtl/decode_useq_eip_incr.sv
// eip_incr: EIP forwarded with a micro-op. Only the final micro-op of an
// instruction without a pending exception advances EIP by the instruction
// length; the sum wraps modulo 2^EIP_W. Also usable by the fetch redirect path.
// Ports:
//   eip_in    in  EIP_W  instruction EIP
//   instr_len in  LEN_W  instruction length (zero-extended before the add)
//   exc_en    in  1      NMI / GP / PF enable, suppresses the advance
//   last_uop  in  1      current micro-op ends the instruction
//   eip_out   out EIP_W  EIP to forward
module eip_incr #(
  parameter int EIP_W = decode_pkg::DEF_EIP_W,
  parameter int LEN_W = decode_pkg::DEF_LEN_W
) (
  input  logic [EIP_W-1:0] eip_in,
  input  logic [LEN_W-1:0] instr_len,
  input  logic             exc_en,
  input  logic             last_uop,
  output logic [EIP_W-1:0] eip_out
);

  logic [EIP_W-1:0] eip_sum;

  // Carry out of the top bit is intentionally dropped.
  assign eip_sum = eip_in + EIP_W'(instr_len);
  assign eip_out = (exc_en || !last_uop) ? eip_in : eip_sum;

endmodule

// File: rtl/decode_useq.sv
// decode_useq: decode stage 2 micro-op sequencer. Chooses the control-store
// address each cycle (entry address in IDLE, latched next address in SEQ),
// counts micro-ops, guards against runaway sequences and stalls decode
// stage 1 while an instruction still has micro-ops to issue.
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   d2_v, ld_d2                 D2 valid / AG accepts D2
//   decode_addr, opcode_size    entry address and its opcode size
//   cs_uop_stall, cs_next_addr  fields of the control word read at cs_addr
//   int_exist, repne_term       flush the current sequence
//   exc_en, eip_in, instr_len   EIP advance inputs
//   cs_addr, cs_op_size         control-store address / opcode-size select
//   uop_stall_out               hold D1, more micro-ops follow
//   in_seq                      state is SEQ (exposes FSM state)
//   uop_idx                     index of current micro-op (0 = entry)
//   last_uop                    current micro-op ends the instruction
//   eip_out                     EIP forwarded with this micro-op
//   uop_overflow                sticky, instruction exceeded MAX_UOPS
module decode_useq
  import decode_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NEXT_W   = DEF_NEXT_W,
  parameter int EIP_W    = DEF_EIP_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int MAX_UOPS = DEF_MAX_UOPS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        d2_v,
  input  logic                        ld_d2,
  input  logic [ADDR_W-1:0]           decode_addr,
  input  logic                        opcode_size,
  input  logic                        cs_uop_stall,
  input  logic [NEXT_W-1:0]           cs_next_addr,
  input  logic                        int_exist,
  input  logic                        repne_term,
  input  logic                        exc_en,
  input  logic [EIP_W-1:0]            eip_in,
  input  logic [LEN_W-1:0]            instr_len,
  output logic [ADDR_W-1:0]           cs_addr,
  output logic                        cs_op_size,
  output logic                        uop_stall_out,
  output logic                        in_seq,
  output logic [$clog2(MAX_UOPS)-1:0] uop_idx,
  output logic                        last_uop,
  output logic [EIP_W-1:0]            eip_out,
  output logic                        uop_overflow
);

  localparam int IDX_W = $clog2(MAX_UOPS);

  useq_state_t       state_q, state_d;
  logic [NEXT_W-1:0] next_q, next_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic              flush;
  logic              adv;

  // Handshake: the micro-op presented on D2 (d2_v) is consumed only when AG
  // takes it (ld_d2) in the same cycle; with either low, all state holds.
  assign adv   = d2_v & ld_d2;
  assign flush = int_exist | repne_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      next_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (flush) begin
      // Abandon the instruction, even if this micro-op is being accepted.
      state_d = IDLE;
      idx_d   = '0;
    end else if (adv && cs_uop_stall && idx_q == IDX_W'(MAX_UOPS - 1)) begin
      // Control store asks for more micro-ops than the counter can index.
      state_d = IDLE;
      idx_d   = '0;
      ovf_d   = 1'b1;
    end else if (adv && cs_uop_stall) begin
      state_d = SEQ;
      next_d  = cs_next_addr;
      idx_d   = idx_q + IDX_W'(1);
    end else if (adv) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  always_comb begin
    cs_addr    = decode_addr;
    cs_op_size = opcode_size;
    if (state_q == SEQ) begin
      cs_addr    = ADDR_W'(next_q);
      cs_op_size = 1'b0;
    end
  end

  assign uop_stall_out = d2_v & cs_uop_stall & ~flush;
  assign last_uop      = d2_v & ~cs_uop_stall;
  assign in_seq        = (state_q == SEQ);
  assign uop_idx       = idx_q;
  assign uop_overflow  = ovf_q;

  eip_incr #(
    .EIP_W (EIP_W),
    .LEN_W (LEN_W)
  ) u_eip_incr (
    .eip_in    (eip_in),
    .instr_len (instr_len),
    .exc_en    (exc_en),
    .last_uop  (last_uop),
    .eip_out   (eip_out)
  );

endmodule

// File: tb/tb_decode_useq.sv
// Bench for decode_useq: directed vectors, expected responses queued by the
// driver and compared by a monitor on the falling edge.
module tb_decode_useq;

  localparam int ADDR_W = 8;
  localparam int NEXT_W = 7;
  localparam int EIP_W  = 32;
  localparam int LEN_W  = 4;
  localparam int MAXU   = 8;
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              op;
    logic              stall;
    logic              seq;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic [EIP_W-1:0]  eip;
    logic              ovf;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              d2_v, ld_d2, opcode_size, cs_uop_stall;
  logic [ADDR_W-1:0] decode_addr;
  logic [NEXT_W-1:0] cs_next_addr;
  logic              int_exist, repne_term, exc_en;
  logic [EIP_W-1:0]  eip_in;
  logic [LEN_W-1:0]  instr_len;
  logic [ADDR_W-1:0] cs_addr;
  logic              cs_op_size, uop_stall_out, in_seq, last_uop, uop_overflow;
  logic [IDX_W-1:0]  uop_idx;
  logic [EIP_W-1:0]  eip_out;

  decode_useq #(
    .ADDR_W(ADDR_W), .NEXT_W(NEXT_W), .EIP_W(EIP_W), .LEN_W(LEN_W), .MAX_UOPS(MAXU)
  ) dut (
    .clk(clk), .reset(reset), .d2_v(d2_v), .ld_d2(ld_d2),
    .decode_addr(decode_addr), .opcode_size(opcode_size),
    .cs_uop_stall(cs_uop_stall), .cs_next_addr(cs_next_addr),
    .int_exist(int_exist), .repne_term(repne_term), .exc_en(exc_en),
    .eip_in(eip_in), .instr_len(instr_len),
    .cs_addr(cs_addr), .cs_op_size(cs_op_size), .uop_stall_out(uop_stall_out),
    .in_seq(in_seq), .uop_idx(uop_idx), .last_uop(last_uop),
    .eip_out(eip_out), .uop_overflow(uop_overflow)
  );

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               checks = 0;
  int               errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {cs_addr, cs_op_size, uop_stall_out, in_seq, uop_idx, last_uop, eip_out, uop_overflow};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got addr=%h op=%b stall=%b seq=%b idx=%0d last=%b eip=%h ovf=%b, required addr=%h op=%b stall=%b seq=%b idx=%0d last=%b eip=%h ovf=%b",
                 n, a.addr, a.op, a.stall, a.seq, a.idx, a.last, a.eip, a.ovf,
                 e.addr, e.op, e.stall, e.seq, e.idx, e.last, e.eip, e.ovf);
      end
    end
  end

  // driver: inputs already set by caller; queue the expectation for this
  // cycle, then advance to just after the next rising edge.
  task automatic step(input string n, input logic [ADDR_W-1:0] ea, input logic eop,
                      input logic est, input logic esq, input logic [IDX_W-1:0] eidx,
                      input logic elast, input logic [EIP_W-1:0] eeip, input logic eovf);
    exp_t e;
    e = '{addr: ea, op: eop, stall: est, seq: esq, idx: eidx, last: elast, eip: eeip, ovf: eovf};
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_case(input bit use_repne);
    d2_v = 1; ld_d2 = 1; decode_addr = 8'hA0; opcode_size = 1; cs_uop_stall = 1;
    cs_next_addr = 7'h31; eip_in = 32'h4000; instr_len = 4'd6;
    step("flush_u0", 8'hA0, 1, 1, 0, 0, 0, 32'h4000, 0);
    cs_next_addr = 7'h32;
    step("flush_u1", 8'h31, 0, 1, 1, 1, 0, 32'h4000, 0);
    if (use_repne) repne_term = 1; else int_exist = 1;
    cs_next_addr = 7'h33;
    step("flush_cycle", 8'h32, 0, 0, 1, 2, 0, 32'h4000, 0);
    int_exist = 0; repne_term = 0; d2_v = 0; ld_d2 = 0;
    step("flush_after", 8'hA0, 1, 0, 0, 0, 0, 32'h4000, 0);
  endtask

  initial begin
    reset = 1; d2_v = 0; ld_d2 = 0; decode_addr = 8'h33; opcode_size = 1;
    cs_uop_stall = 0; cs_next_addr = '0; int_exist = 0; repne_term = 0;
    exc_en = 0; eip_in = 32'h55; instr_len = '0;
    @(posedge clk); #1;
    step("reset_state", 8'h33, 1, 0, 0, 0, 0, 32'h55, 0);
    reset = 0;

    // single micro-op instruction
    d2_v = 1; ld_d2 = 1; decode_addr = 8'h45; opcode_size = 0; cs_uop_stall = 0;
    eip_in = 32'h1000; instr_len = 4'd3;
    step("single_uop", 8'h45, 0, 0, 0, 0, 1, 32'h1003, 0);
    d2_v = 0; ld_d2 = 0;
    step("single_after", 8'h45, 0, 0, 0, 0, 0, 32'h1000, 0);

    // three micro-op sequence
    d2_v = 1; ld_d2 = 1; decode_addr = 8'h80; opcode_size = 1; cs_uop_stall = 1;
    cs_next_addr = 7'h12; eip_in = 32'h2000; instr_len = 4'd5;
    step("seq3_u0", 8'h80, 1, 1, 0, 0, 0, 32'h2000, 0);
    cs_next_addr = 7'h13;
    step("seq3_u1", 8'h12, 0, 1, 1, 1, 0, 32'h2000, 0);
    cs_uop_stall = 0;
    step("seq3_u2", 8'h13, 0, 0, 1, 2, 1, 32'h2005, 0);
    d2_v = 0; ld_d2 = 0;
    step("seq3_done", 8'h80, 1, 0, 0, 0, 0, 32'h2000, 0);

    // AG stall mid-sequence
    d2_v = 1; ld_d2 = 1; decode_addr = 8'h90; opcode_size = 0; cs_uop_stall = 1;
    cs_next_addr = 7'h21; eip_in = 32'h3000; instr_len = 4'd2;
    step("agst_u0", 8'h90, 0, 1, 0, 0, 0, 32'h3000, 0);
    ld_d2 = 0; cs_next_addr = 7'h22;
    for (int i = 0; i < 4; i++) step("agst_hold", 8'h21, 0, 1, 1, 1, 0, 32'h3000, 0);
    ld_d2 = 1; cs_uop_stall = 0;
    step("agst_resume", 8'h21, 0, 0, 1, 1, 1, 32'h3002, 0);
    d2_v = 0; ld_d2 = 0;
    step("agst_done", 8'h90, 0, 0, 0, 0, 0, 32'h3000, 0);

    // flush by interrupt, then by REPNE termination
    flush_case(1'b0);
    flush_case(1'b1);

    // overflow: eight accepted micro-ops all asking for more
    d2_v = 1; ld_d2 = 1; decode_addr = 8'hB0; opcode_size = 0; cs_uop_stall = 1;
    eip_in = 32'h5000; instr_len = 4'd1;
    for (int k = 0; k < MAXU; k++) begin
      cs_next_addr = NEXT_W'(8'h40 + k);
      step("ovf_uop", (k == 0) ? 8'hB0 : ADDR_W'(8'h40 + k - 1), 0, 1, (k != 0),
           IDX_W'(k), 0, 32'h5000, 0);
    end
    d2_v = 0; ld_d2 = 0;
    step("ovf_set", 8'hB0, 0, 0, 0, 0, 0, 32'h5000, 1);
    d2_v = 1; ld_d2 = 1; cs_next_addr = 7'h50;
    step("ovf_sticky_u0", 8'hB0, 0, 1, 0, 0, 0, 32'h5000, 1);
    ld_d2 = 0;
    step("ovf_sticky_u1", 8'h50, 0, 1, 1, 1, 0, 32'h5000, 1);
    reset = 1;
    step("reset_mid_seq", 8'hB0, 0, 1, 0, 0, 0, 32'h5000, 0);
    reset = 0; d2_v = 0;
    step("post_reset", 8'hB0, 0, 0, 0, 0, 0, 32'h5000, 0);

    // EIP wrap and exception suppression
    d2_v = 1; ld_d2 = 1; decode_addr = 8'h10; cs_uop_stall = 0;
    eip_in = 32'hFFFF_FFFE; instr_len = 4'd4; exc_en = 0;
    step("eip_wrap", 8'h10, 0, 0, 0, 0, 1, 32'h0000_0002, 0);
    exc_en = 1;
    step("eip_exc", 8'h10, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    exc_en = 0; eip_in = 32'h10; instr_len = 4'hF;
    step("eip_maxlen", 8'h10, 0, 0, 0, 0, 1, 32'h1F, 0);
    d2_v = 0; ld_d2 = 0;

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_useq.md
# decode_useq

Parametrised micro-op sequencer for decode stage 2. It replaces the single-bit micro-op select register with a two-state sequencer that has:
- a micro-op index counter;
- an overflow guard;
- flush on interrupt or REPNE termination;
- EIP advance only on the final micro-op of an instruction.

It sits between the decode-address path and the micro control store. It selects each cycle's control-store address and produces the stall that holds decode stage 1.

## Interface
Parameters:
- ADDR_W, 8, control-store address width
- NEXT_W, 7, width of the control word's next-micro-address field (NEXT_W < ADDR_W)
- EIP_W, 32, instruction pointer width
- LEN_W, 4, instruction length width
- MAX_UOPS, 8, maximum micro-ops per instruction (power of two, ≥2)

Ports (reset is asynchronous and active-high; one clock):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- d2_v  in  1  valid instruction in D2
- ld_d2  in  1  downstream (AG) accepts D2 this cycle
- decode_addr  in  ADDR_W  entry address for a new instruction
- opcode_size  in  1  opcode size for the entry address
- cs_uop_stall  in  1  current control word: more micro-ops follow
- cs_next_addr  in  NEXT_W  current control word: next micro address
- int_exist  in  1  interrupt pending, flush sequence
- repne_term  in  1  WB REPNE terminate-all, flush sequence
- exc_en  in  1  NMI / GP / PF enable for this instruction
- eip_in  in  EIP_W  instruction EIP
- instr_len  in  LEN_W  instruction length
- cs_addr  out  ADDR_W  control-store address
- cs_op_size  out  1  control-store opcode-size select
- uop_stall_out  out  1  hold D1 (more micro-ops this instruction)
- in_seq  out  1  sequencer is in SEQ state
- uop_idx  out  $clog2(MAX_UOPS)  index of current micro-op (0 = entry)
- last_uop  out  1  current micro-op ends the instruction
- eip_out  out  EIP_W  EIP forwarded with this micro-op
- uop_overflow  out  1  sticky: instruction exceeded MAX_UOPS

## Operation
- flush = int_exist | repne_term. adv = d2_v & ld_d2.
- States: IDLE (entry micro-op) and SEQ (continuation micro-ops).
- In IDLE:
  - cs_addr = decode_addr.
  - cs_op_size = opcode_size.
- In SEQ:
  - cs_addr = zero-extended next_q.
  - cs_op_size = 0.
- Transitions, in priority order:
  - flush → IDLE, idx 0. This wins over everything except reset.
  - adv & cs_uop_stall & idx == MAX_UOPS-1 → IDLE, idx 0, uop_overflow set.
  - adv & cs_uop_stall → SEQ, next_q ← cs_next_addr, idx+1.
  - adv & !cs_uop_stall → IDLE, idx 0.
  - !adv → hold all state. This covers both ld_d2 = 0 (AG stall) and d2_v = 0.
- uop_stall_out = d2_v & cs_uop_stall & !flush (combinational).
- last_uop = d2_v & !cs_uop_stall.
- eip_out:
  - eip_in when exc_en = 1 or last_uop = 0.
  - Otherwise eip_in + zero-extended instr_len, modulo 2^EIP_W (wraps, no carry out).
- uop_overflow clears only on reset.

## Timing
- Reset values:
  - state IDLE, next_q 0, idx 0, in_seq 0, uop_overflow 0.
  - cs_addr = decode_addr and cs_op_size = opcode_size, since both follow combinationally from IDLE.
- cs_addr, cs_op_size, uop_stall_out, last_uop and eip_out are combinational from current state and inputs, with zero latency. The control word read at cs_addr feeds back cs_uop_stall and cs_next_addr in the same cycle.
- Micro-op n+1 is addressed the cycle after micro-op n is accepted. Throughput is one micro-op per cycle when ld_d2 = 1.
- A flush in the same cycle as adv: the flush wins, the instruction is abandoned, and there is no EIP advance requirement on the flushed micro-op.
- Reset asserted mid-sequence: the sequencer returns to IDLE immediately and asynchronously. The next instruction starts at decode_addr.

## Structure
- Shared package decode_pkg holds:
  - useq_state_t enum {IDLE, SEQ};
  - default ADDR_W, NEXT_W, EIP_W constants.
- One sub-module, eip_incr: a parametrised EIP_W adder plus exc_en/last_uop select, reusable by the fetch redirect path.
- Sequencer state, next_q, idx and overflow live in the top module.

## Test plan
- Single-uop instruction: decode_addr = 0x45, cs_uop_stall = 0, eip_in = 0x1000, instr_len = 3, ld_d2 = 1 → cs_addr = 0x45, last_uop = 1, eip_out = 0x1003, state stays IDLE.
- Three-uop sequence: entry 0x80, next addresses 0x12 then 0x13, stall 1,1,0 → cs_addr 0x80, 0x12, 0x13 on consecutive cycles; uop_idx 0,1,2; eip_out = eip_in on the first two micro-ops and eip_in + len on the third.
- AG stall mid-sequence: ld_d2 = 0 for 4 cycles in SEQ with idx = 1 → cs_addr, uop_idx and uop_stall_out all held for 4 cycles, then resume.
- Flush: int_exist = 1 while in SEQ with idx = 2 → next cycle IDLE, idx 0, uop_stall_out = 0 in the flush cycle. Repeat with repne_term.
- Overflow: cs_uop_stall held 1 for MAX_UOPS accepted micro-ops → after the 8th micro-op, uop_overflow = 1 (sticky), state IDLE. An asynchronous reset then clears it.
- EIP wrap/exception: eip_in = 0xFFFFFFFE, len = 4 → eip_out = 0x00000002; the same case with exc_en = 1 → eip_out = 0xFFFFFFFE.
